backup_memory: RTL and testbench
================================

Name: backup_memory

Overview:
- Behavioural main-memory model that backs the riscv_top processor in simulation.
- Serves cache-line reads as a burst of four data beats and accepts single-beat masked writes, all over a valid/ready request channel with tags.
- Storage is a plain array named ram, one entry per data word. Benches preload it by hierarchical $readmemh, so the array name and layout are part of the interface.

Parameters:
- DATA_BITS, 128, width of one data beat and of one ram entry.
- ADDR_BITS, 28, width of the request address in data-word units (byte address = addr×16).
- TAG_BITS, 5, width of the request/response tag.
- DEPTH_LOG2, 16, ram holds 2^DEPTH_LOG2 entries.
- DATA_CYCLES, 4, beats per read burst. Fixed at 4 to match the 2-bit offset.

Ports:
- clk, input, 1, clock; all state changes on rising edge.
- reset, input, 1, synchronous, active-high.
- mem_req_valid, input, 1, request present.
- mem_req_ready, output, 1, request can be accepted.
- mem_req_rw, input, 1, 0 = read burst, 1 = write.
- mem_req_addr, input, ADDR_BITS, word address.
- mem_req_tag, input, TAG_BITS, request tag.
- mem_req_data_valid, input, 1, write beat present.
- mem_req_data_ready, output, 1, write beat can be accepted.
- mem_req_data_bits, input, DATA_BITS, write data.
- mem_req_data_mask, input, DATA_BITS/8, byte enables; bit i covers data bits [8i+7:8i].
- mem_req_data_offset, input, 2, beat index of the write within the aligned 4-word block.
- mem_resp_valid, output, 1, response beat valid.
- mem_resp_tag, output, TAG_BITS, tag of the read being answered.
- mem_resp_data, output, DATA_BITS, read data.

Behaviour:
- Index and aliasing
  - base = {addr[ADDR_BITS-1:2], 2'b00}, truncated to DEPTH_LOG2 bits.
  - Upper address bits are ignored, so addresses alias and wrap modulo the ram size.
- States: IDLE, WDATA, RRESP.
- IDLE
  - mem_req_ready = 1 and mem_req_data_ready = 0.
  - A request is accepted on any rising edge where mem_req_valid && mem_req_ready.
  - On acceptance, latch base and tag.
  - If rw = 0, go to RRESP with beat counter = 0; if rw = 1, go to WDATA.
- RRESP
  - mem_req_ready = 0.
  - For 4 consecutive cycles, starting the cycle after acceptance: mem_resp_valid = 1, mem_resp_tag = latched tag, mem_resp_data = ram[base + beat].
  - Beats run 0, 1, 2, 3 in order, ignoring the original low two address bits (aligned wrap).
  - There is no response backpressure.
  - After beat 3, return to IDLE. The next request can be accepted in the cycle following beat 3.
- WDATA
  - mem_req_ready = 0 and mem_req_data_ready = 1.
  - On mem_req_data_valid, write ram[base + mem_req_data_offset]. Only bytes whose mask bit is 1 change; mask = 0 leaves the word unchanged.
  - Return to IDLE on that same edge.
  - Stays in WDATA indefinitely until a beat arrives.
  - Writes produce no response.
- Idle outputs: when mem_resp_valid = 0, mem_resp_tag and mem_resp_data are driven 0.
- Reset
  - While reset is high: state goes to IDLE, all outputs go to their IDLE values, and mem_resp_valid = 0.
  - ram contents are NOT cleared, so a preload survives reset.
  - Reset asserted mid-burst aborts the remaining beats.
  - Reset asserted in WDATA drops the pending write.
  - Requests are not accepted while reset is high.
- Ordering: a read accepted after a completed write observes the written data.
- Undefined ram: entries not preloaded read as X; no check is made on them.
- Not synthesizable-critical: a simulation model, no timing constraints.

Test Plan:
- Read burst: preload ram[0..7] = 0x…00 to 0x…07; read addr=5, tag=3 → resp_valid high for exactly 4 cycles starting 1 cycle after acceptance, data ram[4], ram[5], ram[6], ram[7], tag=3 on all beats.
- Masked write: write addr=8, offset=2, data=0xFFFF…FF, mask=0x000F, then read addr=8 → beat 2 has low 4 bytes = 0xFFFFFFFF, other bytes keep preload values.
- Handshake: hold mem_req_valid high continuously with back-to-back reads → second request accepted only in the cycle after the first burst's beat 3; mem_req_data_ready stays 0 throughout.
- Write stall: write request, then data_valid withheld for 5 cycles → req_ready=0 and data_ready=1 for all 5 cycles; the write lands on the cycle data_valid rises; no resp_valid pulse.
- Reset mid-burst: assert reset after beat 1 → no further resp_valid; after release req_ready=1; ram data unchanged.
- Address wrap: read addr = 2^DEPTH_LOG2 + 4 → returns the same beats as addr=4.

Source files
------------

// File: rtl/backup_memory.sv
// Behavioural backing store for riscv_top: 4-beat aligned read bursts and
// single-beat byte-masked writes over a tagged valid/ready request channel.
module backup_memory #(
    parameter int DATA_BITS   = 128,
    parameter int ADDR_BITS   = 28,
    parameter int TAG_BITS    = 5,
    parameter int DEPTH_LOG2  = 16,
    parameter int DATA_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mem_req_valid,
    output logic                   mem_req_ready,
    input  logic                   mem_req_rw,
    input  logic [ADDR_BITS-1:0]   mem_req_addr,
    input  logic [TAG_BITS-1:0]    mem_req_tag,
    input  logic                   mem_req_data_valid,
    output logic                   mem_req_data_ready,
    input  logic [DATA_BITS-1:0]   mem_req_data_bits,
    input  logic [DATA_BITS/8-1:0] mem_req_data_mask,
    input  logic [1:0]             mem_req_data_offset,
    output logic                   mem_resp_valid,
    output logic [TAG_BITS-1:0]    mem_resp_tag,
    output logic [DATA_BITS-1:0]   mem_resp_data
);
    localparam int MASK_BITS = DATA_BITS / 8;

    typedef enum logic [1:0] {IDLE, WDATA, RRESP} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [DEPTH_LOG2-3:0]   block;
    logic [TAG_BITS-1:0]     tag;
    logic [1:0]              beat;
    logic [DEPTH_LOG2-1:0]   read_index;
    logic [DEPTH_LOG2-1:0]   write_index;
    logic                    accept;
    logic                    write_fire;

    // Name and layout are fixed: benches preload this array hierarchically.
    logic [DATA_BITS-1:0]    ram [0:(1<<DEPTH_LOG2)-1];

    // Only the 4-word block index is kept; upper address bits alias.
    generate
        if (ADDR_BITS > DEPTH_LOG2) begin : g_alias
            logic unused_addr_bits;
            assign unused_addr_bits = ^{mem_req_addr[ADDR_BITS-1:DEPTH_LOG2], mem_req_addr[1:0]};
        end else begin : g_no_alias
            logic unused_addr_bits;
            assign unused_addr_bits = ^mem_req_addr[1:0];
        end
    endgenerate

    assign read_index  = {block, beat};
    assign write_index = {block, mem_req_data_offset};
    assign accept      = !reset && (state == IDLE) && mem_req_valid;
    assign write_fire  = !reset && (state == WDATA) && mem_req_data_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            block <= '0;
            tag   <= '0;
            beat  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                block <= mem_req_addr[DEPTH_LOG2-1:2];
                tag   <= mem_req_tag;
                beat  <= '0;
            end else if (state == RRESP) begin
                beat <= beat + 2'd1;
            end
        end
    end

    // Storage is deliberately outside the reset so a preload survives it.
    always_ff @(posedge clk) begin
        if (write_fire) begin
            for (int i = 0; i < MASK_BITS; i++) begin
                if (mem_req_data_mask[i]) begin
                    ram[write_index][8*i +: 8] <= mem_req_data_bits[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_next         = state;
        mem_req_ready      = 1'b0;
        mem_req_data_ready = 1'b0;
        mem_resp_valid     = 1'b0;
        mem_resp_tag       = '0;
        mem_resp_data      = '0;
        case (state)
            IDLE: begin
                mem_req_ready = 1'b1;
                if (mem_req_valid) begin
                    state_next = mem_req_rw ? WDATA : RRESP;
                end
            end
            WDATA: begin
                mem_req_data_ready = 1'b1;
                if (mem_req_data_valid) begin
                    state_next = IDLE;
                end
            end
            RRESP: begin
                mem_resp_valid = 1'b1;
                mem_resp_tag   = tag;
                mem_resp_data  = ram[read_index];
                if (beat == 2'(DATA_CYCLES - 1)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (reset) begin
            state_next         = IDLE;
            mem_req_ready      = 1'b1;
            mem_req_data_ready = 1'b0;
            mem_resp_valid     = 1'b0;
            mem_resp_tag       = '0;
            mem_resp_data      = '0;
        end
    end

endmodule

// File: tb/tb_backup_memory.sv
// Self-checking bench for backup_memory: directed scenarios plus random
// reads/writes scored against a word-array model of the memory.
module tb_backup_memory;
    logic         clk;
    logic         reset;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_req_rw;
    logic [27:0]  mem_req_addr;
    logic [4:0]   mem_req_tag;
    logic         mem_req_data_valid;
    logic         mem_req_data_ready;
    logic [127:0] mem_req_data_bits;
    logic [15:0]  mem_req_data_mask;
    logic [1:0]   mem_req_data_offset;
    logic         mem_resp_valid;
    logic [4:0]   mem_resp_tag;
    logic [127:0] mem_resp_data;

    int compare_count = 0;
    int mismatch_count = 0;

    logic [127:0] model_ram [0:65535];

    backup_memory dut (
        .clk                 (clk),
        .reset               (reset),
        .mem_req_valid       (mem_req_valid),
        .mem_req_ready       (mem_req_ready),
        .mem_req_rw          (mem_req_rw),
        .mem_req_addr        (mem_req_addr),
        .mem_req_tag         (mem_req_tag),
        .mem_req_data_valid  (mem_req_data_valid),
        .mem_req_data_ready  (mem_req_data_ready),
        .mem_req_data_bits   (mem_req_data_bits),
        .mem_req_data_mask   (mem_req_data_mask),
        .mem_req_data_offset (mem_req_data_offset),
        .mem_resp_valid      (mem_resp_valid),
        .mem_resp_tag        (mem_resp_tag),
        .mem_resp_data       (mem_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [127:0] observed,
                               input logic [127:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got %h expected %h", name, observed, expected);
        end
    endtask

    // Model word index: block of the address plus beat, wrapped to the ram size.
    function automatic logic [15:0] modelIndex(input logic [27:0] addr, input int beat);
        return 16'(((addr % 65536) / 4) * 4 + beat);
    endfunction

    task automatic checkBurst(input logic [27:0] addr, input logic [4:0] tag);
        for (int b = 0; b < 4; b++) begin
            checkOutput("rd_resp_valid", mem_resp_valid, 1);
            checkOutput("rd_resp_tag", mem_resp_tag, tag);
            checkOutput("rd_resp_data", mem_resp_data, model_ram[modelIndex(addr, b)]);
            checkOutput("rd_busy_req_ready", mem_req_ready, 0);
            checkOutput("rd_data_ready", mem_req_data_ready, 0);
            @(negedge clk);
        end
        checkOutput("rd_end_resp_valid", mem_resp_valid, 0);
        checkOutput("rd_end_req_ready", mem_req_ready, 1);
    endtask

    task automatic applyRead(input logic [27:0] addr, input logic [4:0] tag);
        @(negedge clk);
        checkOutput("rd_req_ready", mem_req_ready, 1);
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b0;
        mem_req_addr  = addr;
        mem_req_tag   = tag;
        @(negedge clk);
        mem_req_valid = 1'b0;
        checkBurst(addr, tag);
    endtask

    task automatic applyWrite(input logic [27:0] addr, input logic [1:0] offset,
                              input logic [127:0] data, input logic [15:0] mask,
                              input int stall);
        logic [15:0] idx;
        @(negedge clk);
        checkOutput("wr_req_ready", mem_req_ready, 1);
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_addr  = addr;
        mem_req_tag   = 5'($urandom);
        @(negedge clk);
        mem_req_valid = 1'b0;
        repeat (stall) begin
            checkOutput("wr_stall_req_ready", mem_req_ready, 0);
            checkOutput("wr_stall_data_ready", mem_req_data_ready, 1);
            checkOutput("wr_stall_resp_valid", mem_resp_valid, 0);
            @(negedge clk);
        end
        checkOutput("wr_data_ready", mem_req_data_ready, 1);
        mem_req_data_valid  = 1'b1;
        mem_req_data_bits   = data;
        mem_req_data_mask   = mask;
        mem_req_data_offset = offset;
        @(negedge clk);
        mem_req_data_valid = 1'b0;
        checkOutput("wr_done_req_ready", mem_req_ready, 1);
        checkOutput("wr_done_resp_valid", mem_resp_valid, 0);
        idx = modelIndex(addr, int'(offset));
        for (int k = 0; k < 16; k++) begin
            if (mask[k]) model_ram[idx][8*k +: 8] = data[8*k +: 8];
        end
    endtask

    function automatic logic [127:0] randWord();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic applyStimulus();
        logic [27:0] addr;
        // Reset state
        @(negedge clk);
        checkOutput("rst_req_ready", mem_req_ready, 1);
        checkOutput("rst_data_ready", mem_req_data_ready, 0);
        checkOutput("rst_resp_valid", mem_resp_valid, 0);
        checkOutput("rst_resp_tag", mem_resp_tag, 0);
        checkOutput("rst_resp_data", mem_resp_data, 0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_req_ready", mem_req_ready, 1);
        checkOutput("post_rst_resp_valid", mem_resp_valid, 0);

        // Preload words 0..63 through the write port, low word = index
        for (int i = 0; i < 64; i++) begin
            applyWrite(28'(i), 2'(i), {$urandom(), $urandom(), $urandom(), 32'(i)}, 16'hFFFF, 0);
        end

        // Unaligned read returns the aligned block in order
        applyRead(28'd5, 5'd3);

        // Masked write then readback
        applyWrite(28'd8, 2'd2, {128{1'b1}}, 16'h000F, 0);
        applyRead(28'd8, 5'd2);

        // Back-to-back reads with valid held high
        @(negedge clk);
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b0;
        mem_req_addr  = 28'd12;
        mem_req_tag   = 5'd7;
        @(negedge clk);
        mem_req_addr  = 28'd33;
        mem_req_tag   = 5'd9;
        checkBurst(28'd12, 5'd7);
        @(negedge clk);
        mem_req_valid = 1'b0;
        checkBurst(28'd33, 5'd9);

        // Write with data withheld for 5 cycles
        applyWrite(28'd40, 2'd1, randWord(), 16'hFFFF, 5);
        applyRead(28'd41, 5'd1);

        // Reset after beat 1 aborts the burst
        @(negedge clk);
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b0;
        mem_req_addr  = 28'd16;
        mem_req_tag   = 5'd4;
        @(negedge clk);
        mem_req_valid = 1'b0;
        checkOutput("abort_beat0_valid", mem_resp_valid, 1);
        @(negedge clk);
        checkOutput("abort_beat1_data", mem_resp_data, model_ram[17]);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_in_rst_valid", mem_resp_valid, 0);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("abort_after_valid", mem_resp_valid, 0);
            checkOutput("abort_after_ready", mem_req_ready, 1);
        end
        applyRead(28'd16, 5'd5);

        // Reset in WDATA drops the pending write
        @(negedge clk);
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_addr  = 28'd20;
        @(negedge clk);
        mem_req_valid = 1'b0;
        checkOutput("drop_data_ready", mem_req_data_ready, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mem_req_data_valid  = 1'b1;
        mem_req_data_bits   = {128{1'b1}};
        mem_req_data_mask   = 16'hFFFF;
        mem_req_data_offset = 2'd0;
        @(negedge clk);
        checkOutput("drop_idle_data_ready", mem_req_data_ready, 0);
        mem_req_data_valid = 1'b0;
        applyRead(28'd20, 5'd6);

        // Address aliasing beyond the ram size
        applyRead(28'h0010004, 5'd11);
        applyRead(28'd4, 5'd12);

        // Random traffic confined to the preloaded region, random upper bits
        for (int n = 0; n < 40; n++) begin
            addr = (28'($urandom()) & 28'hFFF0000) | 28'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) begin
                applyWrite(addr, 2'($urandom()), randWord(), 16'($urandom()),
                           int'($urandom_range(0, 3)));
            end else begin
                applyRead(addr, 5'($urandom()));
            end
        end
    endtask

    initial begin
        reset               = 1'b1;
        mem_req_valid       = 1'b0;
        mem_req_rw          = 1'b0;
        mem_req_addr        = '0;
        mem_req_tag         = '0;
        mem_req_data_valid  = 1'b0;
        mem_req_data_bits   = '0;
        mem_req_data_mask   = '0;
        mem_req_data_offset = '0;
        repeat (3) @(posedge clk);
        applyStimulus();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
